// File: rtl/draw_scheduler_pkg.sv
// rtl/draw_scheduler_pkg.sv - shared widths, FSM states and index helper for draw_scheduler
package draw_scheduler_pkg;

  localparam int X_W      = 8;
  localparam int Y_W      = 7;
  localparam int COLOUR_W = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_SETTLE,
    ST_DRAW,
    ST_ACK
  } state_t;

  // Next drawer index after idx, wrapping at n.
  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/draw_scheduler_rr_arbiter.sv
// rtl/draw_scheduler_rr_arbiter.sv - combinational round-robin pick of the first request at or after ptr
module draw_scheduler_rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt_onehot,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_valid
);

  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  int             off;
  int             sum;

  // Rotate requests so ptr sits at bit 0, take the lowest set bit, then rotate the index back.
  always_comb begin
    dbl        = {req, req} >> ptr;
    rot        = dbl[N-1:0];
    off        = 0;
    gnt_valid  = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!gnt_valid && rot[i]) begin
        gnt_valid = 1'b1;
        off       = i;
      end
    end
    sum = int'(ptr) + off;
    if (sum >= N) sum = sum - N;
    gnt_idx    = IDX_W'(sum);
    gnt_onehot = gnt_valid ? (N'(1) << gnt_idx) : '0;
  end

endmodule

// File: rtl/draw_scheduler.sv
// rtl/draw_scheduler.sv - grants sprite drawers one at a time onto the single VGA write port
module draw_scheduler
  import draw_scheduler_pkg::*;
#(
  parameter int NUM_DRAWERS = 4,
  parameter int TIMEOUT     = 100,
  parameter int IDX_W       = 2
) (
  input  logic                            clock,
  input  logic                            reset_n,
  input  logic                            hold,
  input  logic [NUM_DRAWERS-1:0]          req,
  input  logic [NUM_DRAWERS-1:0]          drw_done,
  input  logic [X_W*NUM_DRAWERS-1:0]      drw_x,
  input  logic [Y_W*NUM_DRAWERS-1:0]      drw_y,
  input  logic [COLOUR_W*NUM_DRAWERS-1:0] drw_colour,
  input  logic [NUM_DRAWERS-1:0]          drw_writeEn,
  output logic [NUM_DRAWERS-1:0]          start,
  output logic [NUM_DRAWERS-1:0]          ack,
  output logic [X_W-1:0]                  vga_x,
  output logic [Y_W-1:0]                  vga_y,
  output logic [COLOUR_W-1:0]             vga_colour,
  output logic                            vga_writeEn,
  output logic                            busy,
  output logic                            timeout_err
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_t                 state_q, state_d;
  logic [IDX_W-1:0]       gnt_q, gnt_d;
  logic [IDX_W-1:0]       rr_q, rr_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [NUM_DRAWERS-1:0] start_q, start_d;
  logic [NUM_DRAWERS-1:0] ack_q, ack_d;
  logic [X_W-1:0]         vga_x_q, vga_x_d;
  logic [Y_W-1:0]         vga_y_q, vga_y_d;
  logic [COLOUR_W-1:0]    vga_colour_q, vga_colour_d;
  logic                   vga_we_q, vga_we_d;
  logic                   busy_q, busy_d;
  logic                   terr_q, terr_d;

  logic [NUM_DRAWERS-1:0] arb_onehot;
  logic [IDX_W-1:0]       arb_idx;
  logic                   arb_valid;

  draw_scheduler_rr_arbiter #(
    .N     (NUM_DRAWERS),
    .IDX_W (IDX_W)
  ) u_arb (
    .req        (req),
    .ptr        (rr_q),
    .gnt_onehot (arb_onehot),
    .gnt_idx    (arb_idx),
    .gnt_valid  (arb_valid)
  );

  // Next-state and next-output logic; every output is produced one cycle ahead so it can be registered.
  always_comb begin
    state_d      = state_q;
    gnt_d        = gnt_q;
    rr_d         = rr_q;
    cnt_d        = cnt_q;
    start_d      = '0;
    ack_d        = '0;
    vga_x_d      = '0;
    vga_y_d      = '0;
    vga_colour_d = '0;
    vga_we_d     = 1'b0;
    terr_d       = terr_q;
    case (state_q)
      ST_IDLE: begin
        if (!hold && arb_valid) begin
          gnt_d   = arb_idx;
          start_d = arb_onehot;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE:  state_d = ST_SETTLE;
      // The drawer's done is still the stale 1 from its previous run here.
      ST_SETTLE: state_d = ST_DRAW;
      ST_DRAW: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (drw_done[gnt_q]) begin
          ack_d   = NUM_DRAWERS'(1) << gnt_q;
          state_d = ST_ACK;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          terr_d  = 1'b1;
          ack_d   = NUM_DRAWERS'(1) << gnt_q;
          state_d = ST_ACK;
        end else begin
          vga_x_d      = drw_x[gnt_q*X_W +: X_W];
          vga_y_d      = drw_y[gnt_q*Y_W +: Y_W];
          vga_colour_d = drw_colour[gnt_q*COLOUR_W +: COLOUR_W];
          vga_we_d     = drw_writeEn[gnt_q];
        end
      end
      ST_ACK: begin
        rr_d    = IDX_W'(wrap_inc(int'(gnt_q), NUM_DRAWERS));
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // Single state/output register bank; async reset drops everything back to idle zeros.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      gnt_q        <= '0;
      rr_q         <= '0;
      cnt_q        <= '0;
      start_q      <= '0;
      ack_q        <= '0;
      vga_x_q      <= '0;
      vga_y_q      <= '0;
      vga_colour_q <= '0;
      vga_we_q     <= 1'b0;
      busy_q       <= 1'b0;
      terr_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      gnt_q        <= gnt_d;
      rr_q         <= rr_d;
      cnt_q        <= cnt_d;
      start_q      <= start_d;
      ack_q        <= ack_d;
      vga_x_q      <= vga_x_d;
      vga_y_q      <= vga_y_d;
      vga_colour_q <= vga_colour_d;
      vga_we_q     <= vga_we_d;
      busy_q       <= busy_d;
      terr_q       <= terr_d;
    end
  end

  assign start       = start_q;
  assign ack         = ack_q;
  assign vga_x       = vga_x_q;
  assign vga_y       = vga_y_q;
  assign vga_colour  = vga_colour_q;
  assign vga_writeEn = vga_we_q;
  assign busy        = busy_q;
  assign timeout_err = terr_q;

endmodule

// File: doc/draw_scheduler.md
Name: draw_scheduler

Overview:
- Sequences the 8x8 sprite drawer instances (one per texture/direction) onto the single VGA adapter write port.
- Accepts level requests from game logic and grants one drawer at a time, round-robin.
- Pulses the selected drawer's start, forwards its pixel stream to the VGA adapter, and waits for its done.
- Acknowledges the requester, with a watchdog against a hung drawer.

Parameters:
- NUM_DRAWERS, 4, number of drawer instances sharing the VGA port (2..8).
- TIMEOUT, 100, max cycles in DRAW before abort (one 8x8 sprite needs 64 plus margin).
- IDX_W, 2, width of grant index (= clog2 NUM_DRAWERS).

Ports:
- clock  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- hold  in  1  freeze: no new grant while 1 (e.g. screen clear owns the VGA port)
- req  in  NUM_DRAWERS  level request per drawer; held by requester until ack
- drw_done  in  NUM_DRAWERS  done output of each drawer (1 = idle/finished)
- drw_x  in  8*NUM_DRAWERS  flattened drawer x, slice i = [8i+7:8i]
- drw_y  in  7*NUM_DRAWERS  flattened drawer y
- drw_colour  in  3*NUM_DRAWERS  flattened drawer colour
- drw_writeEn  in  NUM_DRAWERS  drawer write enables
- start  out  NUM_DRAWERS  one-hot, one-cycle start pulse to granted drawer
- ack  out  NUM_DRAWERS  one-hot, one-cycle pulse when granted draw finishes or aborts
- vga_x  out  8  to VGA adapter
- vga_y  out  7  to VGA adapter
- vga_colour  out  3  to VGA adapter
- vga_writeEn  out  1  to VGA adapter
- busy  out  1  1 in any state other than IDLE
- timeout_err  out  1  sticky; set on watchdog abort, cleared only by reset

Behaviour:
- Clocking and reset: all outputs registered. Async reset forces state IDLE, grant index 0, rr pointer 0, counter 0. Every output resets to 0.
- Reset mid-draw: the scheduler returns to IDLE immediately. The drawer is not otherwise notified.
- IDLE: if hold=0 and req != 0, select the first set req bit at or after the rr pointer, wrapping modulo NUM_DRAWERS. Latch it as gnt and go to ISSUE. Otherwise stay in IDLE.
- ISSUE (1 cycle): start[gnt]=1. Go to SETTLE.
- SETTLE (1 cycle): drw_done is ignored, because the drawer's done is still the stale 1. Go to DRAW.
- DRAW:
  - Each cycle, register the gnt slice: vga_x/vga_y/vga_colour/vga_writeEn <= drw_x/drw_y/drw_colour/drw_writeEn[gnt]. This is one cycle of latency.
  - Non-granted drawers are never forwarded.
  - When drw_done[gnt]=1, go to ACK.
  - The counter increments each DRAW cycle. At count == TIMEOUT-1 without done, set timeout_err and go to ACK.
- ACK (1 cycle):
  - ack[gnt]=1 and vga_writeEn=0.
  - rr pointer <= gnt+1, wrapping.
  - Counter cleared. Go to IDLE.
- vga_writeEn is 0 in every state except DRAW. vga_x, vga_y and vga_colour are 0 outside DRAW.
- hold only gates IDLE->ISSUE. A draw already in progress completes.
- A req bit dropped mid-draw does not abort the draw; ack still pulses.
- Back-to-back requests have a 3-cycle overhead per grant (ISSUE, SETTLE, ACK) plus 1 IDLE cycle.
- Simultaneous req bits are granted in round-robin order starting at the rr pointer.

Decomposition:
- Shared package/header: X_W=8, Y_W=7, COLOUR_W=3, state encodings (IDLE, ISSUE, SETTLE, DRAW, ACK).
- One natural sub-module: rr_arbiter. It is combinational: req and pointer in, one-hot grant plus index and valid out.

Test Plan:
- Single request with real 8x8 drawers: req=4'b0010, refX=10, refY=20 -> start[1] pulses once. Exactly 64 vga_writeEn cycles, first pixel at (10,20), last at (17,27). ack[1] pulses once; busy returns to 0.
- Contention: req=4'b1011 held from reset, each requester dropping its own bit on its ack -> grants in order 0,1,3. The next req[0] is granted only after 3 (rr wrap). No start overlaps.
- hold=1 with req=4'b0100 -> no start for 50 cycles. Release hold -> start[2] pulses within 2 cycles.
- Hung drawer model (done stuck at 0) with TIMEOUT=100 -> ack pulses after 100 DRAW cycles and timeout_err=1. The next request is still serviced; timeout_err stays 1.
- Reset asserted mid-DRAW (pixel 30) -> all outputs 0 asynchronously, state IDLE. After release, a pending req is re-granted from index 0.
- Isolation: a non-granted drawer driving writeEn=1 with x=255 during a grant -> never appears on the vga_* outputs.
